match_sequencer: RTL and testbench
==================================

Name: match_sequencer

Overview:
- Top-level game-flow controller for the quidditch field: start, countdown, play, pause, goal pause and game over.
- Gates movement of all player controllers via move_enable.
- Pulses positions_reset so players and ball return to kickoff positions.
- Keeps both team scores. Sits between the board buttons / goal detector and the player, ball and VGA overlay blocks; runs on the 25 MHz pixel clock.

Parameters:
- TICKS_PER_SECOND, 25000000, clk cycles per countdown second.
- COUNTDOWN_SECONDS, 3, kickoff countdown length (1..7).
- GOAL_PAUSE_SECONDS, 2, freeze time after a goal (1..7).
- WIN_SCORE, 5, score that ends the match (1..15).
- DEBOUNCE_CYCLES, 250000, stable cycles required on a button before it is accepted.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- start_button  in  1  raw board button, active-low (0 = pressed).
- pause_button  in  1  raw board button, active-low.
- goal_a  in  1  1-cycle pulse: team A scored.
- goal_b  in  1  1-cycle pulse: team B scored.
- move_enable  out  1  1 only in PLAY; player controllers hold position when 0.
- positions_reset  out  1  1-cycle pulse: reload kickoff positions.
- state  out  3  encoded state for the overlay.
- countdown  out  3  seconds remaining in COUNTDOWN/GOAL, else 0.
- score_a  out  4  team A score.
- score_b  out  4  team B score.
- winner  out  2  0 none, 1 team A, 2 team B.

Behaviour:
- Reset is asynchronous and active-low; one clock (clk). On reset: state=IDLE, every output 0, all counters 0.
- Buttons:
  - Each button passes through a 2-flop synchronizer, then a debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A press event is a 1-cycle strobe on the debounced 1->0 edge. Holding a button gives exactly one event.
  - Latency from raw edge to event: DEBOUNCE_CYCLES+3 cycles.
- Second timer:
  - sec_cnt counts 0..TICKS_PER_SECOND-1. sec_tick asserts when it wraps.
  - sec_cnt clears to 0 on every state entry, so the first tick is a full second after entry.
  - sec_cnt holds while PAUSED.
- States (state encoding):
  - IDLE (0): start event -> scores cleared, winner=0, positions_reset pulse, countdown=COUNTDOWN_SECONDS, go to COUNTDOWN.
  - COUNTDOWN (1): on each sec_tick, countdown decrements. If a tick arrives with countdown==1, countdown becomes 0 and the next state is PLAY.
  - PLAY (2): move_enable=1, registered, asserted the cycle the state register is PLAY.
    - Pause event -> PAUSED.
    - goal_a XOR goal_b -> the matching score increments (4-bit, never exceeds WIN_SCORE).
    - If the new score == WIN_SCORE: GAME_OVER, winner set.
    - Otherwise: GOAL, countdown=GOAL_PAUSE_SECONDS.
  - PAUSED (3): move_enable=0. Pause event -> PLAY. Goal pulses are ignored.
  - GOAL (4): countdown decrements on sec_tick. A tick at countdown==1 -> positions_reset pulse, countdown=COUNTDOWN_SECONDS, go to COUNTDOWN.
  - GAME_OVER (5): scores and winner held. Start event -> same action as the start event in IDLE.
  - Codes 6/7 are unreachable; if entered, go to IDLE next cycle.
- Simultaneous and ignored events:
  - goal_a and goal_b in the same cycle: both ignored, no score change.
  - A goal and a pause event in the same PLAY cycle: the goal wins and the pause is dropped.
  - A start event is ignored outside IDLE and GAME_OVER.
  - A pause event is ignored outside PLAY and PAUSED.
  - Goal pulses are ignored outside PLAY.
- positions_reset is high exactly one cycle, concurrent with the state transition that issues it.
- Reset asserted mid-match: immediate return to IDLE, all outputs 0, no pulse on release.

Test Plan:
Common bench parameters: TICKS_PER_SECOND=10, DEBOUNCE_CYCLES=4, COUNTDOWN_SECONDS=3, GOAL_PAUSE_SECONDS=2, WIN_SCORE=2.
1. Reset, then hold start_button low 20 cycles -> one positions_reset pulse. state goes 0->1 with countdown=3. countdown reads 2, 1, 0 at cycles +10, +20, +30 after entry. move_enable=1 from the PLAY entry onward.
2. In PLAY, pulse goal_a -> score_a=1, state=4, countdown=2. After 20 cycles: positions_reset pulse, state=1, countdown=3.
3. Second goal_a in PLAY -> score_a=2, state=5, winner=1, move_enable=0. Further goal pulses leave the scores unchanged.
4. goal_a and goal_b in the same PLAY cycle -> scores unchanged, state stays 2.
5. In PLAY, press pause -> state=3, move_enable=0, goal_b ignored. Press pause again -> state=2. Pause press during COUNTDOWN -> ignored.
6. Bounce start_button (toggle every 2 cycles for 12 cycles) -> no event. Assert rst_n=0 mid-COUNTDOWN -> all outputs 0 asynchronously, state=0.

Source files
------------

// File: rtl/match_sequencer.sv
// Game-flow controller for the quidditch field: kickoff countdown, play, pause,
// goal freeze and game over, plus the score keeping that drives the overlay.
module match_sequencer #(
  parameter int unsigned TICKS_PER_SECOND   = 25000000,
  parameter int unsigned COUNTDOWN_SECONDS  = 3,
  parameter int unsigned GOAL_PAUSE_SECONDS = 2,
  parameter int unsigned WIN_SCORE          = 5,
  parameter int unsigned DEBOUNCE_CYCLES    = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_button,
  input  logic       pause_button,
  input  logic       goal_a,
  input  logic       goal_b,
  output logic       move_enable,
  output logic       positions_reset,
  output logic [2:0] state,
  output logic [2:0] countdown,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [1:0] winner
);

  localparam int unsigned SecW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [SecW-1:0] SecMax    = SecW'(TICKS_PER_SECOND - 1);
  localparam logic [DbW-1:0]  DbMax     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      CdInit    = 3'(COUNTDOWN_SECONDS);
  localparam logic [2:0]      GoalInit  = 3'(GOAL_PAUSE_SECONDS);
  localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StPlay      = 3'd2,
    StPaused    = 3'd3,
    StGoal      = 3'd4,
    StGameOver  = 3'd5
  } state_e;

  // Button conditioning: bit 0 = start, bit 1 = pause (both active-low).
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {pause_button, start_button};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic           sync1_q;
    logic           sync2_q;
    logic           level_q;
    logic           press_q;
    logic [DbW-1:0] cnt_q;

    // Released level (1) after reset so no phantom press appears on release.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        level_q <= 1'b1;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[i];
        sync2_q <= sync1_q;
        press_q <= 1'b0;
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DbMax) begin
          cnt_q   <= '0;
          level_q <= sync2_q;
          press_q <= ~sync2_q;
        end else begin
          cnt_q <= cnt_q + DbW'(1);
        end
      end
    end

    assign press[i] = press_q;
  end

  logic start_evt;
  logic pause_evt;

  assign start_evt = press[0];
  assign pause_evt = press[1];

  state_e          state_q, state_d;
  logic [SecW-1:0] sec_cnt_q, sec_cnt_d;
  logic [2:0]      countdown_q, countdown_d;
  logic [3:0]      score_a_q, score_a_d;
  logic [3:0]      score_b_q, score_b_d;
  logic [1:0]      winner_q, winner_d;
  logic            pos_reset_q, pos_reset_d;
  logic            move_enable_q;
  logic            sec_tick;
  logic            start_act;
  logic [3:0]      goal_score;

  assign sec_tick = (state_q != StPaused) && (sec_cnt_q == SecMax);

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    winner_d    = winner_q;
    pos_reset_d = 1'b0;
    start_act   = 1'b0;
    goal_score  = (goal_a ? score_a_q : score_b_q) + 4'd1;

    case (state_q)
      StIdle:     start_act = start_evt;
      StGameOver: start_act = start_evt;
      StCountdown: begin
        if (sec_tick) begin
          countdown_d = countdown_q - 3'd1;
          if (countdown_q == 3'd1) state_d = StPlay;
        end
      end
      StPlay: begin
        // A lone goal takes priority over a pause arriving in the same cycle.
        if ((goal_a ^ goal_b) && ((goal_a ? score_a_q : score_b_q) < WinScore)) begin
          if (goal_a) score_a_d = goal_score;
          else        score_b_d = goal_score;
          if (goal_score == WinScore) begin
            state_d  = StGameOver;
            winner_d = goal_a ? 2'd1 : 2'd2;
          end else begin
            state_d     = StGoal;
            countdown_d = GoalInit;
          end
        end else if (pause_evt) begin
          state_d = StPaused;
        end
      end
      StPaused: begin
        if (pause_evt) state_d = StPlay;
      end
      StGoal: begin
        if (sec_tick) begin
          if (countdown_q == 3'd1) begin
            pos_reset_d = 1'b1;
            countdown_d = CdInit;
            state_d     = StCountdown;
          end else begin
            countdown_d = countdown_q - 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_act) begin
      score_a_d   = '0;
      score_b_d   = '0;
      winner_d    = '0;
      pos_reset_d = 1'b1;
      countdown_d = CdInit;
      state_d     = StCountdown;
    end
  end

  // Restart the second on every state entry so the first tick is a full second later.
  always_comb begin
    sec_cnt_d = sec_cnt_q + SecW'(1);
    if (state_d != state_q) begin
      sec_cnt_d = '0;
    end else if (state_q == StPaused) begin
      sec_cnt_d = sec_cnt_q;
    end else if (sec_tick) begin
      sec_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sec_cnt_q     <= '0;
      countdown_q   <= '0;
      score_a_q     <= '0;
      score_b_q     <= '0;
      winner_q      <= '0;
      pos_reset_q   <= 1'b0;
      move_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sec_cnt_q     <= sec_cnt_d;
      countdown_q   <= countdown_d;
      score_a_q     <= score_a_d;
      score_b_q     <= score_b_d;
      winner_q      <= winner_d;
      pos_reset_q   <= pos_reset_d;
      move_enable_q <= (state_d == StPlay);
    end
  end

  assign state           = state_q;
  assign countdown       = countdown_q;
  assign score_a         = score_a_q;
  assign score_b         = score_b_q;
  assign winner          = winner_q;
  assign positions_reset = pos_reset_q;
  assign move_enable     = move_enable_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Randomized bench for match_sequencer: a timeline model predicts every output
// change, and a negedge monitor pops and compares each change it observes.
module tb_match_sequencer;

  localparam int TPS = 10;
  localparam int DB  = 4;
  localparam int CS  = 3;
  localparam int GP  = 2;
  localparam int WIN = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_button = 1'b1;
  logic       pause_button = 1'b1;
  logic       goal_a = 1'b0;
  logic       goal_b = 1'b0;
  logic       move_enable;
  logic       positions_reset;
  logic [2:0] state;
  logic [2:0] countdown;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic [1:0] winner;

  match_sequencer #(
    .TICKS_PER_SECOND  (TPS),
    .COUNTDOWN_SECONDS (CS),
    .GOAL_PAUSE_SECONDS(GP),
    .WIN_SCORE         (WIN),
    .DEBOUNCE_CYCLES   (DB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_button   (start_button),
    .pause_button   (pause_button),
    .goal_a         (goal_a),
    .goal_b         (goal_b),
    .move_enable    (move_enable),
    .positions_reset(positions_reset),
    .state          (state),
    .countdown      (countdown),
    .score_a        (score_a),
    .score_b        (score_b),
    .winner         (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [2:0] cd;
    logic [3:0] sa;
    logic [3:0] sb;
    logic [1:0] win;
    logic       me;
    logic       pr;
  } snap_t;

  snap_t exp_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  bit    over;
  int    m_sa, m_sb;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic bit same(snap_t a, snap_t b);
    return a.st == b.st && a.cd == b.cd && a.sa == b.sa && a.sb == b.sb &&
           a.win == b.win && a.me == b.me && a.pr == b.pr;
  endfunction

  // Monitor: every observed output change must match the next predicted one.
  initial begin
    snap_t prev, cur, e;
    prev = '{default: 0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = '{cyc, state, countdown, score_a, score_b, winner, move_enable, positions_reset};
        if (!same(cur, prev)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got st=%0d cd=%0d sa=%0d sb=%0d win=%0d me=%0d pr=%0d required no change",
                     cur.cyc, cur.st, cur.cd, cur.sa, cur.sb, cur.win, cur.me, cur.pr);
          end else begin
            e = exp_q.pop_front();
            if (!same(cur, e) || (e.cyc >= 0 && e.cyc != cur.cyc)) begin
              errors++;
              $display("FAIL event cyc=%0d st=%0d cd=%0d sa=%0d sb=%0d win=%0d me=%0d pr=%0d required cyc=%0d st=%0d cd=%0d sa=%0d sb=%0d win=%0d me=%0d pr=%0d",
                       cur.cyc, cur.st, cur.cd, cur.sa, cur.sb, cur.win, cur.me, cur.pr,
                       e.cyc, e.st, e.cd, e.sa, e.sb, e.win, e.me, e.pr);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int c, input int st, input int cd, input int me, input int pr,
                           input int win);
    snap_t s;
    s.cyc = c; s.st = 3'(st); s.cd = 3'(cd); s.sa = 4'(m_sa); s.sb = 4'(m_sb);
    s.win = 2'(win); s.me = me[0]; s.pr = pr[0];
    exp_q.push_back(s);
  endtask

  // Kickoff timeline from the cycle the countdown is entered.
  task automatic expect_countdown(input int e);
    expect_at(e, 1, CS, 0, 1, 0);
    expect_at(e + 1, 1, CS, 0, 0, 0);
    for (int s = 1; s < CS; s++) expect_at(e + TPS * s, 1, CS - s, 0, 0, 0);
    expect_at(e + TPS * CS, 2, 0, 1, 0, 0);
  endtask

  task automatic expect_goal(input bit a, input int g);
    int sc;
    if (a) begin m_sa++; sc = m_sa; end
    else   begin m_sb++; sc = m_sb; end
    if (sc == WIN) begin
      expect_at(g, 5, 0, 0, 0, a ? 1 : 2);
      over = 1'b1;
    end else begin
      expect_at(g, 4, GP, 0, 0, 0);
      for (int s = 1; s < GP; s++) expect_at(g + TPS * s, 4, GP - s, 0, 0, 0);
      expect_countdown(g + TPS * GP);
    end
  endtask

  task automatic set_btn(input bit which, input logic v);
    if (which) pause_button = v;
    else       start_button = v;
  endtask

  // Full debounced press; k is the cycle the raw line went low.
  task automatic press(input bit which, output int k);
    tick(1);
    k = cyc;
    set_btn(which, 1'b0);
    tick(DB + 6);
    set_btn(which, 1'b1);
    tick(DB + 4);
  endtask

  task automatic pulse_goals(input bit a, input bit b, input bit predict);
    tick(1);
    if (predict) expect_goal(a, cyc + 1);
    goal_a = a;
    goal_b = b;
    tick(1);
    goal_a = 1'b0;
    goal_b = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_countdown"}, int'(countdown), 0);
    chk({tag, "_score_a"}, int'(score_a), 0);
    chk({tag, "_score_b"}, int'(score_b), 0);
    chk({tag, "_winner"}, int'(winner), 0);
    chk({tag, "_move_enable"}, int'(move_enable), 0);
    chk({tag, "_positions_reset"}, int'(positions_reset), 0);
  endtask

  initial begin
    int k;
    int act;

    #1 rst_n = 1'b0;
    #20;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick(3);

    // Bouncing start line never holds long enough to register.
    for (int seg = 0; seg < 6; seg++) begin
      start_button = seg[0];
      tick(2);
    end
    start_button = 1'b1;
    tick(DB + 8);

    for (int g = 0; g < 3; g++) begin
      m_sa = 0;
      m_sb = 0;
      over = 1'b0;
      tick($urandom_range(1, 6));
      tick(1);
      k = cyc;
      expect_countdown(k + DB + 3);
      start_button = 1'b0;
      tick(DB + 6);
      start_button = 1'b1;
      tick(DB + 4);

      if (g == 2) begin
        // Asynchronous reset in the middle of the kickoff countdown.
        @(negedge clk);
        #2;
        exp_q.delete();
        expect_at(-1, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        tick(2);
        rst_n = 1'b1;
        tick(40);
        wait_drain(5);
        break;
      end

      if (g == 0) press(1'b1, k);  // pause ignored during countdown
      wait_drain(200);

      for (int it = 0; it < 40 && !over; it++) begin
        act = (g == 0 && it < 3) ? it + 2 : int'($urandom_range(0, 4));
        tick($urandom_range(0, 5));
        case (act)
          0: pulse_goals(1'b1, 1'b0, 1'b1);
          1: pulse_goals(1'b0, 1'b1, 1'b1);
          2: begin
            pulse_goals(1'b1, 1'b1, 1'b0);
            tick(3);
          end
          3: begin
            tick(1);
            k = cyc;
            expect_at(k + DB + 3, 3, 0, 0, 0, 0);
            pause_button = 1'b0;
            tick(DB + 6);
            pause_button = 1'b1;
            tick(DB + 4);
            pulse_goals(1'b0, 1'b1, 1'b0);
            pulse_goals(1'b1, 1'b0, 1'b0);
            tick(1);
            k = cyc;
            expect_at(k + DB + 3, 2, 0, 1, 0, 0);
            pause_button = 1'b0;
            tick(DB + 6);
            pause_button = 1'b1;
            tick(DB + 4);
          end
          default: begin
            // Goal lands in the same cycle the pause press is recognised.
            bit a;
            a = 1'($urandom_range(0, 1));
            tick(1);
            pause_button = 1'b0;
            tick(DB + 2);
            expect_goal(a, cyc + 1);
            goal_a = a;
            goal_b = ~a;
            tick(1);
            goal_a = 1'b0;
            goal_b = 1'b0;
            tick(4);
            pause_button = 1'b1;
            tick(DB + 4);
          end
        endcase
        wait_drain(200);
      end
      chk("game_finished", int'(over), 1);

      // Scores frozen in GAME_OVER; goal pulses must not produce any change.
      pulse_goals(1'b1, 1'b0, 1'b0);
      pulse_goals(1'b0, 1'b1, 1'b0);
      tick(3);
      chk("final_score_a", int'(score_a), m_sa);
      chk("final_score_b", int'(score_b), m_sb);
    end

    wait_drain(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
